// File: rtl/mc_cu_pkg.sv
// rtl/mc_cu_pkg.sv - state, opcode, ALU and mux-select encodings for the multi-cycle control unit
package mc_cu_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    // Don't-care MSB of the two-operand codes is driven as 0.
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] ALUSRCB_REGB   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_REGA   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_lui;
        logic i_j;
        logic i_jal;
        logic r_type;
        logic legal;
    } instr_t;

    // ALU operation for the execute phase of a decoded instruction.
    function automatic logic [3:0] exe_aluc(input instr_t d);
        logic [3:0] c;
        c = ALUC_ADD;
        if (d.i_sub || d.i_beq || d.i_bne) c = ALUC_SUB;
        if (d.i_and || d.i_andi)           c = ALUC_AND;
        if (d.i_or  || d.i_ori)            c = ALUC_OR;
        if (d.i_xor || d.i_xori)           c = ALUC_XOR;
        if (d.i_lui)                       c = ALUC_LUI;
        if (d.i_sll)                       c = ALUC_SLL;
        if (d.i_srl)                       c = ALUC_SRL;
        if (d.i_sra)                       c = ALUC_SRA;
        return c;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/func to one-hot instruction flags
module mc_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output instr_t     instr
);

    logic r;

    assign r = (op == OP_RTYPE);

    // One flag per supported instruction; legal is the OR of them all.
    always_comb begin
        instr        = '0;
        instr.r_type = r;
        instr.i_add  = r && (func == FN_ADD);
        instr.i_sub  = r && (func == FN_SUB);
        instr.i_and  = r && (func == FN_AND);
        instr.i_or   = r && (func == FN_OR);
        instr.i_xor  = r && (func == FN_XOR);
        instr.i_sll  = r && (func == FN_SLL);
        instr.i_srl  = r && (func == FN_SRL);
        instr.i_sra  = r && (func == FN_SRA);
        instr.i_jr   = r && (func == FN_JR);
        instr.i_addi = (op == OP_ADDI);
        instr.i_andi = (op == OP_ANDI);
        instr.i_ori  = (op == OP_ORI);
        instr.i_xori = (op == OP_XORI);
        instr.i_lw   = (op == OP_LW);
        instr.i_sw   = (op == OP_SW);
        instr.i_beq  = (op == OP_BEQ);
        instr.i_bne  = (op == OP_BNE);
        instr.i_lui  = (op == OP_LUI);
        instr.i_j    = (op == OP_J);
        instr.i_jal  = (op == OP_JAL);
        instr.legal  = instr.i_add  | instr.i_sub  | instr.i_and  | instr.i_or   |
                       instr.i_xor  | instr.i_sll  | instr.i_srl  | instr.i_sra  |
                       instr.i_jr   | instr.i_addi | instr.i_andi | instr.i_ori  |
                       instr.i_xori | instr.i_lw   | instr.i_sw   | instr.i_beq  |
                       instr.i_bne  | instr.i_lui  | instr.i_j    | instr.i_jal;
    end

endmodule

// File: rtl/mc_cu.sv
// rtl/mc_cu.sv - multi-cycle control unit: state register plus per-state datapath controls
module mc_cu
    import mc_cu_pkg::*;
#(
    parameter int            SW          = 3,
    parameter logic [SW-1:0] RESET_STATE = 3'd0
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [5:0]    op,
    input  logic [5:0]    func,
    input  logic          z,
    output logic          wpc,
    output logic          wir,
    output logic          wmem,
    output logic          wreg,
    output logic          iord,
    output logic          regrt,
    output logic          m2reg,
    output logic          jal,
    output logic          sext,
    output logic          shift,
    output logic          alusrca,
    output logic [1:0]    alusrcb,
    output logic [3:0]    aluc,
    output logic [1:0]    pcsource,
    output logic [SW-1:0] state
);

    instr_t        d;
    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          wpc_c;
    logic          wir_c;
    logic          wmem_c;
    logic          wreg_c;

    mc_decode u_decode (
        .op    (op),
        .func  (func),
        .instr (d)
    );

    // State register; reset lands in IF without waiting for a clock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= RESET_STATE;
        else         state_q <= state_d;
    end

    // Next state and datapath controls for the current phase.
    always_comb begin
        state_d  = S_IF;
        wpc_c    = 1'b0;
        wir_c    = 1'b0;
        wmem_c   = 1'b0;
        wreg_c   = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ALUSRCB_REGB;
        aluc     = ALUC_ADD;
        pcsource = PCSRC_ALU;
        case (state_q)
            S_IF: begin
                wpc_c   = 1'b1;
                wir_c   = 1'b1;
                alusrcb = ALUSRCB_FOUR;
                state_d = S_ID;
            end
            S_ID: begin
                // ALU precomputes the branch target while the instruction is decoded.
                alusrcb = ALUSRCB_BRANCH;
                sext    = 1'b1;
                if (d.i_j || d.i_jal) begin
                    wpc_c    = 1'b1;
                    pcsource = PCSRC_JUMP;
                    wreg_c   = d.i_jal;
                    jal      = d.i_jal;
                end else if (d.i_jr) begin
                    wpc_c    = 1'b1;
                    pcsource = PCSRC_REGA;
                end else if (d.legal) begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                shift   = d.i_sll | d.i_srl | d.i_sra;
                alusrcb = (d.r_type || d.i_beq || d.i_bne) ? ALUSRCB_REGB : ALUSRCB_IMM;
                aluc    = exe_aluc(d);
                sext    = ~(d.i_andi | d.i_ori | d.i_xori);
                if (d.i_beq || d.i_bne) begin
                    wpc_c    = (d.i_beq & z) | (d.i_bne & ~z);
                    pcsource = PCSRC_ALUOUT;
                end else if (d.i_lw || d.i_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                iord    = 1'b1;
                wmem_c  = d.i_sw;
                state_d = d.i_lw ? S_WB : S_IF;
            end
            S_WB: begin
                wreg_c = 1'b1;
                regrt  = ~d.r_type;
                m2reg  = d.i_lw;
            end
            default: state_d = S_IF;
        endcase
    end

    // Write enables are suppressed for as long as reset is held.
    assign wpc   = wpc_c  & resetn;
    assign wir   = wir_c  & resetn;
    assign wmem  = wmem_c & resetn;
    assign wreg  = wreg_c & resetn;
    assign state = state_q;

endmodule

// File: tb/tb_mc_cu.sv
// tb/tb_mc_cu.sv - randomized instruction stream checked against a per-cycle instruction model
module tb_mc_cu;

    typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_NOP} kind_e;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        kind_e      kind;
        logic [3:0] aluc;
        bit         alu_x;
        bit         shamt;
        bit         rtype;
        bit         zext;
    } ins_t;

    typedef struct packed {
        logic [2:0] state;
        logic       wpc;
        logic       wir;
        logic       wmem;
        logic       wreg;
        logic       iord;
        logic       regrt;
        logic       m2reg;
        logic       jal;
        logic       sext;
        logic       shift;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsource;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic [2:0] state;

    int   checks = 0;
    int   errors = 0;
    ins_t tbl[22];

    mc_cu dut (
        .clock    (clock),
        .resetn   (resetn),
        .op       (op),
        .func     (func),
        .z        (z),
        .wpc      (wpc),
        .wir      (wir),
        .wmem     (wmem),
        .wreg     (wreg),
        .iord     (iord),
        .regrt    (regrt),
        .m2reg    (m2reg),
        .jal      (jal),
        .sext     (sext),
        .shift    (shift),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluc     (aluc),
        .pcsource (pcsource),
        .state    (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input kind_e k,
                                input logic [3:0] a, input bit ax, input bit sh,
                                input bit rt, input bit zx);
        ins_t t;
        t.op = o; t.fn = f; t.kind = k; t.aluc = a; t.alu_x = ax;
        t.shamt = sh; t.rtype = rt; t.zext = zx;
        return t;
    endfunction

    function automatic int cpi(input ins_t t);
        case (t.kind)
            K_J, K_JAL, K_JR, K_NOP: return 2;
            K_BEQ, K_BNE:            return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected controls for cycle c of instruction t, from the instruction's phase rules.
    function automatic vec_t model(input ins_t t, input int c, input bit zz);
        vec_t e = '0;
        if (c == 0) begin
            e.state = 3'd0; e.wpc = 1; e.wir = 1; e.alusrcb = 2'b01;
        end else if (c == 1) begin
            e.state = 3'd1; e.alusrcb = 2'b11; e.sext = 1;
            if (t.kind == K_J || t.kind == K_JAL) begin
                e.wpc = 1; e.pcsource = 2'b11;
            end
            if (t.kind == K_JAL) begin
                e.wreg = 1; e.jal = 1;
            end
            if (t.kind == K_JR) begin
                e.wpc = 1; e.pcsource = 2'b10;
            end
        end else if (c == 2) begin
            e.state = 3'd2; e.alusrca = 1; e.shift = t.shamt;
            e.alusrcb = (t.rtype || t.kind == K_BEQ || t.kind == K_BNE) ? 2'b00 : 2'b10;
            e.aluc = t.aluc; e.sext = !t.zext;
            if (t.kind == K_BEQ) begin e.wpc = zz;  e.pcsource = 2'b01; end
            if (t.kind == K_BNE) begin e.wpc = !zz; e.pcsource = 2'b01; end
        end else if (c == 3 && (t.kind == K_LW || t.kind == K_SW)) begin
            e.state = 3'd3; e.iord = 1; e.wmem = (t.kind == K_SW);
        end else if (c == 3) begin
            e.state = 3'd4; e.wreg = 1; e.regrt = !t.rtype;
        end else begin
            e.state = 3'd4; e.wreg = 1; e.regrt = 1; e.m2reg = 1;
        end
        return e;
    endfunction

    function automatic vec_t sample();
        vec_t g;
        g.state = state; g.wpc = wpc; g.wir = wir; g.wmem = wmem; g.wreg = wreg;
        g.iord = iord; g.regrt = regrt; g.m2reg = m2reg; g.jal = jal; g.sext = sext;
        g.shift = shift; g.alusrca = alusrca; g.alusrcb = alusrcb; g.aluc = aluc;
        g.pcsource = pcsource;
        return g;
    endfunction

    // IF-phase controls with every write enable held low.
    function automatic vec_t reset_vec();
        vec_t e = '0;
        e.alusrcb = 2'b01;
        return e;
    endfunction

    // Compare with the MSB of aluc ignored when the expected code leaves it open.
    task automatic cmp(input string tag, input vec_t e, input bit msb_dc);
        vec_t g;
        g = sample();
        if (msb_dc) g.aluc[3] = e.aluc[3];
        check(tag, 32'(g), 32'(e));
    endtask

    // Runs one instruction from IF; entered and left 1 time unit after a rising edge.
    task automatic run_instr(input int idx, input int n, input int abort_at);
        ins_t t;
        bit   dc;
        t    = tbl[idx];
        op   = t.op;
        func = t.fn;
        for (int c = 0; c < cpi(t); c++) begin
            z = 1'($urandom);
            @(negedge clock);
            dc = (c <= 1) || (c == 2 && t.alu_x);
            cmp($sformatf("i%0d op%h fn%h c%0d", n, t.op, t.fn, c), model(t, c, z), dc);
            if (c == abort_at) begin
                #1 resetn = 1'b0;
                #1 cmp($sformatf("i%0d rst_async", n), reset_vec(), 1'b1);
                @(posedge clock);
                #1 cmp($sformatf("i%0d rst_hold", n), reset_vec(), 1'b1);
                resetn = 1'b1;
                return;
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        tbl[0]  = mk(6'h00, 6'h20, K_ALU, 4'b0000, 1, 0, 1, 0);
        tbl[1]  = mk(6'h00, 6'h22, K_ALU, 4'b0100, 1, 0, 1, 0);
        tbl[2]  = mk(6'h00, 6'h24, K_ALU, 4'b0001, 1, 0, 1, 0);
        tbl[3]  = mk(6'h00, 6'h25, K_ALU, 4'b0101, 1, 0, 1, 0);
        tbl[4]  = mk(6'h00, 6'h26, K_ALU, 4'b0010, 1, 0, 1, 0);
        tbl[5]  = mk(6'h00, 6'h00, K_ALU, 4'b0011, 0, 1, 1, 0);
        tbl[6]  = mk(6'h00, 6'h02, K_ALU, 4'b0111, 0, 1, 1, 0);
        tbl[7]  = mk(6'h00, 6'h03, K_ALU, 4'b1111, 0, 1, 1, 0);
        tbl[8]  = mk(6'h00, 6'h08, K_JR,  4'b0000, 1, 0, 1, 0);
        tbl[9]  = mk(6'h08, 6'h15, K_ALU, 4'b0000, 1, 0, 0, 0);
        tbl[10] = mk(6'h0c, 6'h3a, K_ALU, 4'b0001, 1, 0, 0, 1);
        tbl[11] = mk(6'h0d, 6'h07, K_ALU, 4'b0101, 1, 0, 0, 1);
        tbl[12] = mk(6'h0e, 6'h20, K_ALU, 4'b0010, 1, 0, 0, 1);
        tbl[13] = mk(6'h23, 6'h11, K_LW,  4'b0000, 1, 0, 0, 0);
        tbl[14] = mk(6'h2b, 6'h2c, K_SW,  4'b0000, 1, 0, 0, 0);
        tbl[15] = mk(6'h04, 6'h01, K_BEQ, 4'b0100, 1, 0, 0, 0);
        tbl[16] = mk(6'h05, 6'h3f, K_BNE, 4'b0100, 1, 0, 0, 0);
        tbl[17] = mk(6'h0f, 6'h08, K_ALU, 4'b0110, 1, 0, 0, 0);
        tbl[18] = mk(6'h02, 6'h20, K_J,   4'b0000, 1, 0, 0, 0);
        tbl[19] = mk(6'h03, 6'h00, K_JAL, 4'b0000, 1, 0, 0, 0);
        tbl[20] = mk(6'h00, 6'h3f, K_NOP, 4'b0000, 1, 0, 1, 0);
        tbl[21] = mk(6'h3f, 6'h20, K_NOP, 4'b0000, 1, 0, 0, 0);

        resetn = 1'b0;
        op     = 6'h00;
        func   = 6'h20;
        z      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            cmp($sformatf("reset%0d", i), reset_vec(), 1'b1);
        end
        @(posedge clock);
        #1 resetn = 1'b1;

        // Directed: add, lw, sw, beq, bne, jal, then addi abandoned in EXE.
        run_instr(0, 0, -1);
        run_instr(13, 1, -1);
        run_instr(14, 2, -1);
        run_instr(15, 3, -1);
        run_instr(16, 4, -1);
        run_instr(19, 5, -1);
        run_instr(9, 6, 2);
        run_instr(9, 7, -1);

        for (int n = 8; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) run_instr(int'($urandom_range(0, 21)), n, int'($urandom_range(0, 1)));
            else                            run_instr(int'($urandom_range(0, 21)), n, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
